// File: rtl/dlx_pkg.sv
// Shared DLX definitions used by the instruction-fetch front end.
//   NOP_INSTR    : word presented to decode when no instruction is available
//   DLX_RESET_PC : default first fetch address after reset
//   if_entry_t   : one queue entry, fetched instruction plus the PC it came from
//   word_align   : clears the byte-offset bits of an address
package dlx_pkg;

    localparam logic [31:0] NOP_INSTR    = 32'h5400_0000;
    localparam logic [31:0] DLX_RESET_PC = 32'h0000_0000;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } if_entry_t;

    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return addr & 32'hFFFF_FFFC;
    endfunction

endpackage

// File: rtl/if_prefetch_if.sv
// Bundle of the fetch unit's bus signals.
//   imem_* : request/grant/response handshake towards instruction memory
//   stall, branch, branch_pc : control from the decode stage
//   inst_valid, inst_id, pc_plus_four_id : instruction handed to decode
// master is the fetch unit; slave is the memory/decode side.
interface if_prefetch_if;

    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;

    logic        stall;
    logic        branch;
    logic [31:0] branch_pc;

    logic        inst_valid;
    logic [31:0] inst_id;
    logic [31:0] pc_plus_four_id;

    modport master (
        output imem_req, imem_addr, inst_valid, inst_id, pc_plus_four_id,
        input  imem_gnt, imem_rvalid, imem_rdata, stall, branch, branch_pc
    );

    modport slave (
        input  imem_req, imem_addr, inst_valid, inst_id, pc_plus_four_id,
        output imem_gnt, imem_rvalid, imem_rdata, stall, branch, branch_pc
    );

endinterface

// File: rtl/sync_fifo.sv
// Synchronous in-order FIFO with registered storage and no bypass.
//   clk_i, rst_ni : clock and synchronous active-low reset
//   push_i/data_i : write an entry (caller guarantees not full)
//   pop_i         : drop the head entry (caller guarantees not empty)
//   flush_i       : empty the queue; overrides push and pop
//   data_o        : head entry, meaningful only when count_o != 0
//   count_o       : number of stored entries, 0..Depth
module sync_fifo #(
    parameter int unsigned Width = 32,
    parameter int unsigned Depth = 4
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       push_i,
    input  logic [Width-1:0]           data_i,
    input  logic                       pop_i,
    input  logic                       flush_i,
    output logic [Width-1:0]           data_o,
    output logic [$clog2(Depth+1)-1:0] count_o
);

    localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
    localparam int unsigned CntW = $clog2(Depth + 1);

    logic [Width-1:0] mem_q [Depth];
    logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0]  count_q, count_d;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            // Pointers wrap naturally because Depth is a power of two.
            if (push_i) wr_ptr_d = wr_ptr_q + PtrW'(1);
            if (pop_i)  rd_ptr_d = rd_ptr_q + PtrW'(1);
            count_d = count_q + CntW'(push_i) - CntW'(pop_i);
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: the head is only observed while count_q != 0.
    always_ff @(posedge clk_i) begin
        if (push_i && !flush_i) mem_q[wr_ptr_q] <= data_i;
    end

    assign data_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;

endmodule

// File: rtl/if_prefetch.sv
// Instruction-fetch front end: issues word fetches to instruction memory under a
// credit limit, queues returned words with their PCs, and hands one instruction
// per cycle to decode. A branch flushes the queue and drops responses still in
// flight for the old path.
//   clk, rst_n : clock and synchronous active-low reset
//   bus        : memory handshake, decode control and decode-facing outputs
module if_prefetch
    import dlx_pkg::*;
#(
    parameter int unsigned DEPTH     = 4,
    parameter logic [31:0] RESET_PC  = DLX_RESET_PC,
    parameter int unsigned MAX_OUTST = 2
) (
    input logic           clk,
    input logic           rst_n,
    if_prefetch_if.master bus
);

    localparam int unsigned CntW = $clog2(DEPTH + 1);
    localparam int unsigned OutW = $clog2(MAX_OUTST + 1);

    logic [31:0]     fetch_pc_q, fetch_pc_d;
    logic [31:0]     shadow_pc_q, shadow_pc_d;
    logic [OutW-1:0] outst_q, outst_d;
    logic [OutW-1:0] discard_q, discard_d;

    logic [CntW-1:0] count;
    logic [31:0]     target;
    logic            req, fire, push, pop, valid;
    logic            credit_ok, outst_ok;
    if_entry_t       head, push_entry;

    assign target = word_align(bus.branch_pc);
    assign valid  = (count != '0);

    always_comb begin
        // Queued plus in-flight words may never exceed the queue size, so every
        // response is guaranteed a free slot.
        credit_ok  = (32'(count) + 32'(outst_q)) < DEPTH;
        outst_ok   = 32'(outst_q) < MAX_OUTST;
        req        = rst_n && !bus.branch && credit_ok && outst_ok;
        fire       = req && bus.imem_gnt;
        push       = bus.imem_rvalid && !bus.branch && (discard_q == '0);
        pop        = valid && !bus.stall && !bus.branch;
        push_entry = '{pc: shadow_pc_q, instr: bus.imem_rdata};

        fetch_pc_d  = fetch_pc_q;
        shadow_pc_d = shadow_pc_q;
        outst_d     = outst_q;
        discard_d   = discard_q;

        if (bus.branch) begin
            fetch_pc_d  = target;
            shadow_pc_d = target;
            // Everything still in flight belongs to the old path; a response
            // landing this cycle is already dropped, so it is not counted.
            outst_d     = outst_q - OutW'(bus.imem_rvalid);
            discard_d   = outst_q - OutW'(bus.imem_rvalid);
        end else begin
            if (fire) fetch_pc_d = fetch_pc_q + 32'd4;
            if (push) shadow_pc_d = shadow_pc_q + 32'd4;
            outst_d = outst_q + OutW'(fire) - OutW'(bus.imem_rvalid);
            if (bus.imem_rvalid && (discard_q != '0)) discard_d = discard_q - OutW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fetch_pc_q  <= RESET_PC;
            shadow_pc_q <= RESET_PC;
            outst_q     <= '0;
            discard_q   <= '0;
        end else begin
            fetch_pc_q  <= fetch_pc_d;
            shadow_pc_q <= shadow_pc_d;
            outst_q     <= outst_d;
            discard_q   <= discard_d;
        end
    end

    sync_fifo #(
        .Width ($bits(if_entry_t)),
        .Depth (DEPTH)
    ) u_queue (
        .clk_i   (clk),
        .rst_ni  (rst_n),
        .push_i  (push),
        .data_i  (push_entry),
        .pop_i   (pop),
        .flush_i (bus.branch),
        .data_o  (head),
        .count_o (count)
    );

    assign bus.imem_req        = req;
    assign bus.imem_addr       = fetch_pc_q;
    assign bus.inst_valid      = valid;
    assign bus.inst_id         = valid ? head.instr : NOP_INSTR;
    // With an empty queue, report the PC of the next word to arrive.
    assign bus.pc_plus_four_id = valid ? head.pc + 32'd4 : shadow_pc_q + 32'd4;

    assert property (@(posedge clk) disable iff (!rst_n) !(push && count == CntW'(DEPTH)));
    assert property (@(posedge clk) disable iff (!rst_n) !(bus.imem_rvalid && outst_q == '0));

endmodule

// File: tb/tb_if_prefetch.sv
module tb_if_prefetch;

    localparam logic [31:0] NOP     = 32'h5400_0000;
    localparam logic [31:0] WRAP_PC = 32'hFFFF_FFF8;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    if_prefetch_if b ();
    if_prefetch_if bw ();

    if_prefetch #(
        .DEPTH     (4),
        .RESET_PC  (32'h0000_0000),
        .MAX_OUTST (2)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (b)
    );

    if_prefetch #(
        .DEPTH     (4),
        .RESET_PC  (WRAP_PC),
        .MAX_OUTST (2)
    ) dut_w (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bw)
    );

    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;
    int lat      = 1;

    typedef struct {
        logic [31:0] addr;
        int          due;
    } pend_t;
    pend_t pend[$];

    logic        w_fire = 1'b0;
    logic [31:0] w_addr = 32'h0;

    typedef struct {
        bit          rst;
        logic        stall;
        logic        gnt;
        logic        req;
        logic [31:0] addr;
        logic        valid;
        logic [31:0] inst;
        logic [31:0] pc4;
    } vec_t;
    vec_t vecs[$];

    function automatic logic [31:0] mem(input logic [31:0] a);
        return {a[15:0], ~a[15:0]} ^ 32'h1357_0000;
    endfunction

    function automatic vec_t mk(input bit r, input logic s, input logic g, input logic rq,
                                input logic [31:0] a, input logic v, input logic [31:0] i,
                                input logic [31:0] p);
        vec_t x;
        x.rst = r; x.stall = s; x.gnt = g; x.req = rq;
        x.addr = a; x.valid = v; x.inst = i; x.pc4 = p;
        return x;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s (cycle %0d): got %h, want %h", name, cyc, act, exp);
        end
    endtask

    // Drive inputs just after the clock edge, then move to the falling edge to sample.
    task automatic cycle_begin(input logic stall, input logic gnt, input logic br,
                               input logic [31:0] bpc);
        b.stall     = stall;
        b.imem_gnt  = gnt;
        b.branch    = br;
        b.branch_pc = bpc;
        if (rst_n && pend.size() > 0 && pend[0].due <= cyc) begin
            b.imem_rvalid = 1'b1;
            b.imem_rdata  = mem(pend[0].addr);
            pend.delete(0);
        end else begin
            b.imem_rvalid = 1'b0;
            b.imem_rdata  = 32'h0;
        end
        bw.stall       = 1'b0;
        bw.imem_gnt    = 1'b1;
        bw.branch      = 1'b0;
        bw.branch_pc   = 32'h0;
        bw.imem_rvalid = rst_n && w_fire;
        bw.imem_rdata  = mem(w_addr);
        @(negedge clk);
    endtask

    task automatic cycle_end();
        if (rst_n) begin
            if (b.imem_req && b.imem_gnt) pend.push_back('{addr: b.imem_addr, due: cyc + lat});
            w_fire = bw.imem_req && bw.imem_gnt;
            w_addr = bw.imem_addr;
        end else begin
            pend.delete();
            w_fire = 1'b0;
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic reset_dut();
        rst_n = 1'b0;
        for (int i = 0; i < 2; i++) begin
            cycle_begin(1'b0, 1'b0, 1'b0, 32'h0);
            if (i == 1) begin
                chk("rst req", 32'(b.imem_req), 32'h0);
                chk("rst valid", 32'(b.inst_valid), 32'h0);
                chk("rst inst", b.inst_id, NOP);
                chk("rst pc4", b.pc_plus_four_id, 32'h4);
                chk("rst wrap req", 32'(bw.imem_req), 32'h0);
                chk("rst wrap pc4", bw.pc_plus_four_id, 32'hFFFF_FFFC);
            end
            cycle_end();
        end
        rst_n = 1'b1;
        cyc = 0;
        pend.delete();
        w_fire = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0;

        // Streaming, zero-wait memory: first word two cycles after release.
        vecs.push_back(mk(1'b1, 1'b0, 1'b1, 1'b1, 32'h00, 1'b0, NOP, 32'h04));
        vecs.push_back(mk(1'b0, 1'b0, 1'b1, 1'b1, 32'h04, 1'b0, NOP, 32'h04));
        vecs.push_back(mk(1'b0, 1'b0, 1'b1, 1'b1, 32'h08, 1'b1, mem(32'h00), 32'h04));
        vecs.push_back(mk(1'b0, 1'b0, 1'b1, 1'b1, 32'h0C, 1'b1, mem(32'h04), 32'h08));
        vecs.push_back(mk(1'b0, 1'b0, 1'b1, 1'b1, 32'h10, 1'b1, mem(32'h08), 32'h0C));
        vecs.push_back(mk(1'b0, 1'b0, 1'b1, 1'b1, 32'h14, 1'b1, mem(32'h0C), 32'h10));
        // Stall from release for 10 cycles: queue fills to 4, requests stop.
        vecs.push_back(mk(1'b1, 1'b1, 1'b1, 1'b1, 32'h00, 1'b0, NOP, 32'h04));
        vecs.push_back(mk(1'b0, 1'b1, 1'b1, 1'b1, 32'h04, 1'b0, NOP, 32'h04));
        vecs.push_back(mk(1'b0, 1'b1, 1'b1, 1'b1, 32'h08, 1'b1, mem(32'h00), 32'h04));
        vecs.push_back(mk(1'b0, 1'b1, 1'b1, 1'b1, 32'h0C, 1'b1, mem(32'h00), 32'h04));
        for (int k = 4; k < 10; k++)
            vecs.push_back(mk(1'b0, 1'b1, 1'b1, 1'b0, 32'h10, 1'b1, mem(32'h00), 32'h04));
        // Release: back-to-back instructions, refetch resumes.
        vecs.push_back(mk(1'b0, 1'b0, 1'b1, 1'b0, 32'h10, 1'b1, mem(32'h00), 32'h04));
        vecs.push_back(mk(1'b0, 1'b0, 1'b1, 1'b1, 32'h10, 1'b1, mem(32'h04), 32'h08));
        vecs.push_back(mk(1'b0, 1'b0, 1'b1, 1'b1, 32'h14, 1'b1, mem(32'h08), 32'h0C));
        vecs.push_back(mk(1'b0, 1'b0, 1'b1, 1'b1, 32'h18, 1'b1, mem(32'h0C), 32'h10));
        vecs.push_back(mk(1'b0, 1'b0, 1'b1, 1'b1, 32'h1C, 1'b1, mem(32'h10), 32'h14));
        vecs.push_back(mk(1'b0, 1'b0, 1'b1, 1'b1, 32'h20, 1'b1, mem(32'h14), 32'h18));

        lat = 1;
        for (int i = 0; i < vecs.size(); i++) begin
            if (vecs[i].rst) reset_dut();
            cycle_begin(vecs[i].stall, vecs[i].gnt, 1'b0, 32'h0);
            chk($sformatf("vec%0d req", i), 32'(b.imem_req), 32'(vecs[i].req));
            chk($sformatf("vec%0d addr", i), b.imem_addr, vecs[i].addr);
            chk($sformatf("vec%0d valid", i), 32'(b.inst_valid), 32'(vecs[i].valid));
            chk($sformatf("vec%0d inst", i), b.inst_id, vecs[i].inst);
            chk($sformatf("vec%0d pc4", i), b.pc_plus_four_id, vecs[i].pc4);
            cycle_end();
        end

        // Grant withheld for 5 cycles, then a single grant.
        reset_dut();
        for (int k = 0; k < 8; k++) begin
            cycle_begin(1'b0, (k == 5), 1'b0, 32'h0);
            if (k <= 5) begin
                chk("nognt req", 32'(b.imem_req), 32'h1);
                chk("nognt addr", b.imem_addr, 32'h0);
                chk("nognt valid", 32'(b.inst_valid), 32'h0);
            end else if (k == 6) begin
                chk("postgnt addr", b.imem_addr, 32'h4);
                chk("postgnt valid", 32'(b.inst_valid), 32'h0);
            end else begin
                chk("gnt+2 valid", 32'(b.inst_valid), 32'h1);
                chk("gnt+2 inst", b.inst_id, mem(32'h0));
                chk("gnt+2 pc4", b.pc_plus_four_id, 32'h4);
            end
            cycle_end();
        end

        // Branch to 0x103 with two requests in flight (two-cycle memory).
        lat = 2;
        reset_dut();
        cycle_begin(1'b0, 1'b1, 1'b0, 32'h0); cycle_end();
        cycle_begin(1'b0, 1'b1, 1'b0, 32'h0); cycle_end();
        cycle_begin(1'b0, 1'b1, 1'b1, 32'h103);
        chk("br req", 32'(b.imem_req), 32'h0);
        cycle_end();
        cycle_begin(1'b0, 1'b1, 1'b0, 32'h0);
        chk("br+1 req", 32'(b.imem_req), 32'h1);
        chk("br+1 addr", b.imem_addr, 32'h100);
        chk("br+1 valid", 32'(b.inst_valid), 32'h0);
        chk("br+1 pc4", b.pc_plus_four_id, 32'h104);
        cycle_end();
        cycle_begin(1'b0, 1'b1, 1'b0, 32'h0);
        chk("br+2 addr", b.imem_addr, 32'h104);
        chk("br+2 valid", 32'(b.inst_valid), 32'h0);
        cycle_end();
        cycle_begin(1'b0, 1'b1, 1'b0, 32'h0);
        chk("br+3 req", 32'(b.imem_req), 32'h0);
        chk("br+3 valid", 32'(b.inst_valid), 32'h0);
        cycle_end();
        cycle_begin(1'b0, 1'b1, 1'b0, 32'h0);
        chk("br+4 valid", 32'(b.inst_valid), 32'h1);
        chk("br+4 inst", b.inst_id, mem(32'h100));
        chk("br+4 pc4", b.pc_plus_four_id, 32'h104);
        cycle_end();
        cycle_begin(1'b0, 1'b1, 1'b0, 32'h0);
        chk("br+5 inst", b.inst_id, mem(32'h104));
        chk("br+5 pc4", b.pc_plus_four_id, 32'h108);
        cycle_end();
        lat = 1;

        // Branch, stall and a response all in the same cycle.
        reset_dut();
        for (int k = 0; k < 3; k++) begin
            cycle_begin(1'b0, 1'b1, 1'b0, 32'h0);
            cycle_end();
        end
        cycle_begin(1'b1, 1'b1, 1'b1, 32'h200);
        chk("bsr rvalid driven", 32'(b.imem_rvalid), 32'h1);
        chk("bsr req", 32'(b.imem_req), 32'h0);
        cycle_end();
        cycle_begin(1'b0, 1'b1, 1'b0, 32'h0);
        chk("bsr+1 valid", 32'(b.inst_valid), 32'h0);
        chk("bsr+1 inst", b.inst_id, NOP);
        chk("bsr+1 req", 32'(b.imem_req), 32'h1);
        chk("bsr+1 addr", b.imem_addr, 32'h200);
        cycle_end();
        cycle_begin(1'b0, 1'b1, 1'b0, 32'h0);
        chk("bsr+2 valid", 32'(b.inst_valid), 32'h0);
        chk("bsr+2 addr", b.imem_addr, 32'h204);
        cycle_end();
        cycle_begin(1'b0, 1'b1, 1'b0, 32'h0);
        chk("bsr+3 inst", b.inst_id, mem(32'h200));
        chk("bsr+3 pc4", b.pc_plus_four_id, 32'h204);
        cycle_end();

        // PC wrap on the instance that starts at 0xFFFF_FFF8.
        reset_dut();
        for (int k = 0; k < 5; k++) begin
            cycle_begin(1'b0, 1'b1, 1'b0, 32'h0);
            case (k)
                0: chk("wrap addr0", bw.imem_addr, 32'hFFFF_FFF8);
                1: begin
                    chk("wrap addr1", bw.imem_addr, 32'hFFFF_FFFC);
                    chk("wrap valid1", 32'(bw.inst_valid), 32'h0);
                end
                2: begin
                    chk("wrap addr2", bw.imem_addr, 32'h0);
                    chk("wrap inst2", bw.inst_id, mem(32'hFFFF_FFF8));
                    chk("wrap pc4_2", bw.pc_plus_four_id, 32'hFFFF_FFFC);
                end
                3: begin
                    chk("wrap inst3", bw.inst_id, mem(32'hFFFF_FFFC));
                    chk("wrap pc4_3", bw.pc_plus_four_id, 32'h0);
                end
                default: begin
                    chk("wrap inst4", bw.inst_id, mem(32'h0));
                    chk("wrap pc4_4", bw.pc_plus_four_id, 32'h4);
                end
            endcase
            cycle_end();
        end

        // One-cycle reset in the middle of a stream.
        reset_dut();
        for (int k = 0; k < 4; k++) begin
            cycle_begin(1'b0, 1'b1, 1'b0, 32'h0);
            cycle_end();
        end
        rst_n = 1'b0;
        cycle_begin(1'b0, 1'b1, 1'b0, 32'h0);
        chk("midrst req", 32'(b.imem_req), 32'h0);
        cycle_end();
        rst_n = 1'b1;
        cycle_begin(1'b0, 1'b1, 1'b0, 32'h0);
        chk("midrst+1 valid", 32'(b.inst_valid), 32'h0);
        chk("midrst+1 inst", b.inst_id, NOP);
        chk("midrst+1 req", 32'(b.imem_req), 32'h1);
        chk("midrst+1 addr", b.imem_addr, 32'h0);
        chk("midrst+1 pc4", b.pc_plus_four_id, 32'h4);
        cycle_end();
        cycle_begin(1'b0, 1'b1, 1'b0, 32'h0);
        chk("midrst+2 addr", b.imem_addr, 32'h4);
        chk("midrst+2 valid", 32'(b.inst_valid), 32'h0);
        cycle_end();
        cycle_begin(1'b0, 1'b1, 1'b0, 32'h0);
        chk("midrst+3 inst", b.inst_id, mem(32'h0));
        chk("midrst+3 pc4", b.pc_plus_four_id, 32'h4);
        cycle_end();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/if_prefetch.md
# if_prefetch

Instruction-fetch front end of the 5-stage DLX pipeline. It drives the instruction memory through a request/grant/response handshake, buffers fetched words with their PCs in a small in-order queue, and presents one instruction per cycle to the decode stage. Decode can hold it off with `stall` or redirect it with `branch`/`branch_pc`. It replaces the free-running PC register plus combinational fetch, so that instruction memory may have variable latency.

## Interface
- `DEPTH`, 4: instruction queue entries (power of two, ≥2)
- `RESET_PC`, 32'h0000_0000: first fetch address after reset
- `MAX_OUTST`, 2: maximum in-flight memory requests
- `clk` in 1: clock; all state updates on its rising edge
- `rst_n` in 1: synchronous, active-low reset
- `imem_req` out 1: fetch request valid
- `imem_addr` out 32: word-aligned fetch address; bits [1:0] are always 0
- `imem_gnt` in 1: memory accepts the request this cycle
- `imem_rvalid` in 1: response data valid; responses return in request order
- `imem_rdata` in 32: instruction word
- `stall` in 1: decode holds the current instruction
- `branch` in 1: redirect fetch (decode's should_branch)
- `branch_pc` in 32: redirect target; bits [1:0] are ignored
- `inst_valid` out 1: `inst_id` holds a real instruction
- `inst_id` out 32: instruction word to decode; reads as NOP when `inst_valid` is 0
- `pc_plus_four_id` out 32: PC of `inst_id` + 4

## Operation
- State:
  - `fetch_pc`, the next address to request.
  - Queue of {pc, instr}, with a `count` of 0..DEPTH entries.
  - `outst`, requests granted but not yet answered (0..MAX_OUTST).
  - `discard`, responses still to be dropped (0..MAX_OUTST).
- Issue: `imem_req` = !branch && (count + outst < DEPTH) && (outst < MAX_OUTST).
  - `imem_addr` = `fetch_pc`.
  - When req && gnt: `fetch_pc` += 4 and `outst` increments.
- Response: when `imem_rvalid` is high, `outst` decrements.
  - If `discard` > 0: drop the word and decrement `discard`.
  - Otherwise push {pc, imem_rdata}. The entry's pc comes from a shadow PC that advances by 4 per accepted response.
- Output: head entry. `inst_valid` = count>0. Pop when inst_valid && !stall.
- Redirect (`branch`=1) takes priority over everything else:
  - The queue is flushed and `count` goes to 0.
  - `fetch_pc` and the shadow PC load `{branch_pc[31:2],2'b00}`.
  - `discard` loads `outst` − (imem_rvalid ? 1 : 0).
  - No request is issued in the redirect cycle.
  - A response arriving in the redirect cycle is dropped.
  - `stall` is ignored in the redirect cycle, and no pop is counted.
- Simultaneous push and pop: `count` is unchanged. Push while full cannot occur because of the issue credit rule; an assertion checks it.
- Reset: when `rst_n`=0 at a clock edge, all state clears.
  - Resulting state: `fetch_pc`=RESET_PC, count=0, outst=0, discard=0.
  - Instruction memory shares `rst_n`, so no stale responses arrive after reset.
  - Reset mid-transfer abandons the transfer with no residue.
- PC arithmetic is modulo 2^32. Wrap from 32'hFFFF_FFFC to 0 is legal and silent.

## Timing
- Reset values:
  - imem_req=0 while in reset; it rises in the first cycle after release with `imem_addr`=RESET_PC.
  - inst_valid=0.
  - inst_id=32'h5400_0000 (NOP).
  - pc_plus_four_id=RESET_PC+4.
- Latency: a response accepted in cycle N appears on `inst_id` with `inst_valid` in cycle N+1, because the queue output is registered and there is no bypass.
  - With zero-wait memory (gnt same cycle, rvalid next), the first instruction appears 2 cycles after reset release.
  - Sustained throughput is 1 instruction/cycle.
- `imem_req`/`imem_addr` are held stable until `imem_gnt`, except in a redirect cycle, where req drops.
- First post-redirect request is issued in cycle N+1 at the target.
- The first target instruction appears on `inst_id` no earlier than N+3, after all outstanding responses have been discarded.

## Structure
- Shared package `dlx_pkg`:
  - `NOP_INSTR` constant.
  - `if_entry_t` typedef {pc[31:0], instr[31:0]}.
  - `DLX_RESET_PC` default.
- Sub-module `sync_fifo`, parameterised by width and depth. It holds the queue and exposes push/pop/flush/count.
- The top level holds the PC, credit and discard logic.

## Test plan
- Zero-wait memory, no stall:
  - inst_id sequence is mem[0], mem[4], mem[8]…
  - pc_plus_four_id is 4, 8, 12…
  - One instruction per cycle from cycle 2.
- gnt held low for 5 cycles: `imem_req`/`imem_addr`=0x0 stay stable, then one grant. inst_valid=0 until 2 cycles after that grant.
- stall held 10 cycles:
  - count saturates at 4 and `imem_req` deasserts.
  - inst_id stays mem[0].
  - On release, 4 back-to-back instructions follow without a bubble.
- branch to 0x103 with 2 requests in flight:
  - Both responses are dropped.
  - Next `imem_addr`=0x100.
  - First valid inst_id is mem[0x100] with pc_plus_four_id=0x104.
- branch, stall and rvalid in the same cycle: the response is dropped, the queue is empty the next cycle, and the target is fetched.
- Wrap and mid-stream reset:
  - RESET_PC=0xFFFF_FFF8 fetches FFF8, FFFC, then 0x0.
  - rst_n low for 1 cycle mid-stream: inst_valid=0 the next cycle and refetch starts at RESET_PC.
